imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//   Fetch controller and arbiter for the single-read-port instruction ROM (imem).
//   - Owns the fetch PC and sequences word reads into a 2-entry instruction queue.
//   - The queue feeds the IF/ID register through a valid/ready handshake.
//   - Shares the ROM port with a debug/trace reader.
//   - Handles branch redirects from the pipeline by flushing the queue.
//   - Sits between imem and the fetch stage of the pipelined processor.
// PARAMETERS
//   N        32  instruction width (matches imem N)
//   AW       6   imem word-address width (64 words)
//   PCW      64  PC width; word address = pc[AW+1:2]
//   RESET_PC 0   fetch PC after reset
// PORTS
//   clk         in   1    clock, rising edge
//   reset       in   1    synchronous, active-high
//   imem_addr   out  AW   address to imem (combinational from arbiter)
//   imem_q      in   N    imem read data, same-cycle (combinational ROM)
//   br_taken    in   1    redirect request from the pipeline
//   br_target   in   PCW  redirect byte address (bits [1:0] ignored)
//   out_valid   out  1    queue head holds a valid instruction
//   out_ready   in   1    fetch stage accepts the head this cycle
//   out_instr   out  N    head instruction
//   out_pc      out  PCW  PC of head instruction
//   dbg_req     in   1    debug read request; held until dbg_gnt
//   dbg_addr    in   AW   debug word address
//   dbg_gnt     out  1    debug owns imem_addr this cycle (combinational)
//   dbg_valid   out  1    dbg_data valid; 1-cycle pulse, the cycle after dbg_gnt
//   dbg_data    out  N    registered debug read data
// BEHAVIOUR
//   Reset state:
//     fetch_pc=RESET_PC; queue empty; out_valid=0; dbg_valid=0; dbg_data=0;
//     starve_cnt=0. imem_addr = RESET_PC[AW+1:2] during reset.
//   Queue timing:
//     fetch_want = !br_taken && (count<2 || (out_valid && out_ready)).
//     The same-cycle pop frees a slot, so there is no bubble at full.
//   Arbitration (1 ROM access/cycle):
//     - dbg_gnt = dbg_req && !(fetch_want && starve_cnt==2).
//     - starve_cnt counts consecutive cycles where fetch was blocked by debug.
//       It clears on any fetch grant and saturates at 2.
//     - Result: fetch is never blocked more than 2 cycles in a row.
//   Fetch grant (fetch_want && !dbg_gnt):
//     imem_addr=fetch_pc[AW+1:2]; push {fetch_pc, imem_q}; fetch_pc += 4.
//   Address wrap:
//     fetch_pc increments at full PCW. The ROM address wraps modulo 2^AW
//     words (word 63 -> 0).
//   Handshake:
//     - A pop occurs when out_valid && out_ready.
//     - Head data stays stable while out_valid && !out_ready.
//   Redirect (br_taken):
//     - Next cycle the queue is empty and fetch_pc = {br_target[PCW-1:2],2'b00}.
//     - No push happens in the redirect cycle.
//     - A handshake in the same cycle still completes: the head counts as consumed.
//     - Debug grant is unaffected by redirect.
//   Debug reads:
//     dbg_data <= imem_q and dbg_valid <= 1 on the edge after the dbg_gnt cycle;
//     otherwise dbg_valid <= 0.
//   Reset mid-operation:
//     A pending dbg_valid is dropped and queued instructions are discarded.
//     The debug requester must re-issue.
//   Outputs out_valid/out_instr/out_pc come from registers (queue head),
//   so there is no combinational path from imem_q to out_*.
// STRUCTURE
//   imem_fetch_pkg:
//     typedef fetch_entry_t {logic [PCW-1:0] pc; logic [N-1:0] instr;}.
//     Constants QDEPTH=2 and STARVE_MAX=2.
//   Sub-module fetch_queue:
//     2-entry FIFO of fetch_entry_t with push/pop/flush, count, full/empty.
//     Flush has priority over push.
//   Top level: fetch_pc register, arbiter + starve_cnt, debug data register.
// TESTING
//   1. Reset, out_ready=1, no debug:
//      out_pc=0,4,8 on consecutive cycles; out_instr=imem word 0,1,2
//      (default image 32'hf8000000, 32'hf8008001, 32'hf8010002).
//   2. out_ready=0 for 5 cycles:
//      queue fills to 2, imem_addr holds, out_pc stays 0.
//      On release, pc 0,4,8 stream with no gap and no duplicate.
//   3. br_taken with br_target=0x40 while queue full and out_ready=1:
//      next cycle out_valid=0; the following cycle out_pc=0x40, out_instr=word 16.
//   4. dbg_req held high, dbg_addr=5, fetch wanting:
//      dbg_gnt pattern 1,1,0,1,1,0. dbg_valid pulses the cycle after each grant
//      with dbg_data=word 5.
//   5. Fetch from fetch_pc=0xFC:
//      imem_addr 63 then 0; out_pc=0xFC then 0x100.
//   6. Assert reset with the queue full and a debug grant in flight:
//      next cycle out_valid=0, dbg_valid=0, imem_addr=0.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// ============================================================================
// Module : imem_fetch_pkg
// Brief  : Shared types and constants for the imem fetch controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_fetch_pkg;

  localparam int FE_N       = 32;
  localparam int FE_AW      = 6;
  localparam int FE_PCW     = 64;
  localparam int FE_ENTRY_W = FE_PCW + FE_N;

  localparam int QDEPTH     = 2;
  localparam int STARVE_MAX = 2;

  typedef struct packed {
    logic [FE_PCW-1:0] pc;
    logic [FE_N-1:0]   instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Two-entry instruction FIFO with push/pop/flush; flush beats push.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import imem_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [FE_ENTRY_W-1:0] i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [FE_ENTRY_W-1:0] o_head,
  output logic [1:0]            o_count,
  output logic                  o_empty
);

  localparam logic [1:0] c_qdepth = 2'(QDEPTH);

  fetch_entry_t r_mem [QDEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == c_qdepth);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot a full-queue push needs.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= fetch_entry_t'(i_data);
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module : imem_fetch_ctrl
// Brief  : Fetch PC sequencer and imem port arbiter between fetch and debug.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                N        = FE_N,
  parameter int                AW       = FE_AW,
  parameter int                PCW      = FE_PCW,
  parameter logic [PCW-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [AW-1:0]   imem_addr,
  input  logic [N-1:0]    imem_q,
  input  logic            br_taken,
  input  logic [PCW-1:0]  br_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_instr,
  output logic [PCW-1:0]  out_pc,
  input  logic            dbg_req,
  input  logic [AW-1:0]   dbg_addr,
  output logic            dbg_gnt,
  output logic            dbg_valid,
  output logic [N-1:0]    dbg_data
);

  localparam logic [1:0] c_qdepth     = 2'(QDEPTH);
  localparam logic [1:0] c_starve_max = 2'(STARVE_MAX);

  logic [PCW-1:0] r_fetch_pc;
  logic [1:0]     r_starve;
  logic           r_dbg_valid;
  logic [N-1:0]   r_dbg_data;

  logic [FE_ENTRY_W-1:0] w_head;
  fetch_entry_t          w_head_e;
  logic [1:0]            w_count;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_fetch_want;
  logic                  w_dbg_gnt;
  logic                  w_fetch_gnt;
  logic                  w_unused_tgt;

  assign w_unused_tgt = ^br_target[1:0];

  assign out_valid    = !w_empty;
  assign w_pop        = out_valid && out_ready;
  assign w_fetch_want = !br_taken && ((w_count != c_qdepth) || w_pop);
  // Debug yields only once fetch has been starved for STARVE_MAX cycles.
  assign w_dbg_gnt    = !reset && dbg_req && !(w_fetch_want && (r_starve == c_starve_max));
  assign w_fetch_gnt  = !reset && w_fetch_want && !w_dbg_gnt;

  always_comb begin
    imem_addr = r_fetch_pc[AW+1:2];
    if (reset) begin
      imem_addr = RESET_PC[AW+1:2];
    end else if (w_dbg_gnt) begin
      imem_addr = dbg_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_starve    <= 2'd0;
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      if (br_taken) begin
        r_fetch_pc <= {br_target[PCW-1:2], 2'b00};
      end else if (w_fetch_gnt) begin
        r_fetch_pc <= r_fetch_pc + PCW'(4);
      end

      if (w_fetch_gnt) begin
        r_starve <= 2'd0;
      end else if (w_fetch_want && w_dbg_gnt && (r_starve != c_starve_max)) begin
        r_starve <= r_starve + 2'd1;
      end

      r_dbg_valid <= w_dbg_gnt;
      if (w_dbg_gnt) begin
        r_dbg_data <= imem_q;
      end
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_fetch_gnt),
    .i_data  ({r_fetch_pc, imem_q}),
    .i_pop   (w_pop),
    .i_flush (br_taken),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_head_e  = fetch_entry_t'(w_head);
  assign out_pc    = w_head_e.pc;
  assign out_instr = w_head_e.instr;
  assign dbg_gnt   = w_dbg_gnt;
  assign dbg_valid = r_dbg_valid;
  assign dbg_data  = r_dbg_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module : tb_imem_fetch_ctrl
// Brief  : Directed and random checks of imem_fetch_ctrl against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        br_taken;
  logic [63:0] br_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        dbg_req;
  logic [5:0]  dbg_addr;
  logic        dbg_gnt;
  logic        dbg_valid;
  logic [31:0] dbg_data;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  int          m_blocked;
  bit          m_dv;
  logic [31:0] m_dd;
  bit          m_last_gnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [5:0] a);
    return 32'hf800_0000 | (32'(a) << 15) | 32'(a);
  endfunction

  assign imem_q = rom(imem_addr);

  imem_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .br_taken  (br_taken),
    .br_target (br_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_valid (dbg_valid),
    .dbg_data  (dbg_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare against the model mid-cycle, then advance it.
  task automatic tick(input bit en = 1'b1);
    bit          pop, want, dg;
    logic [5:0]  ea;
    #2;
    pop  = (mq.size() != 0) && out_ready;
    want = !br_taken && ((mq.size() < 2) || pop);
    dg   = !reset && dbg_req && !(want && (m_blocked >= 2));
    ea   = reset ? 6'd0 : (dg ? dbg_addr : m_pc[7:2]);
    if (en) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
      end
      chk("dbg_valid", 64'(dbg_valid), 64'(m_dv));
      if (m_dv) chk("dbg_data", 64'(dbg_data), 64'(m_dd));
      if (!reset) chk("dbg_gnt", 64'(dbg_gnt), 64'(dg));
      chk("imem_addr", 64'(imem_addr), 64'(ea));
    end
    m_last_gnt = dg;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_pc = 64'd0; m_blocked = 0; m_dv = 1'b0; m_dd = 32'd0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (br_taken) begin
        mq.delete();
        m_pc = {br_target[63:2], 2'b00};
      end else if (want && !dg) begin
        mq.push_back('{pc: m_pc, instr: rom(m_pc[7:2])});
        m_pc = m_pc + 64'd4;
      end
      if (want && !dg) m_blocked = 0;
      else if (want)   m_blocked++;
      m_dv = dg;
      if (dg) m_dd = rom(dbg_addr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; br_taken = 1'b0; dbg_req = 1'b0;
    tick(1'b0);
    tick(1'b1);
    reset = 1'b0;
  endtask

  initial begin
    bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b1; br_taken = 1'b0; br_target = 64'd0;
    out_ready = 1'b1; dbg_req = 1'b0; dbg_addr = 6'd0;

    // Reset, then stream from word 0
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dbg_valid", 64'(dbg_valid), 64'd0);
    chk("rst_dbg_data", 64'(dbg_data), 64'd0);
    tick();
    chk("t1_pc0", out_pc, 64'h0);
    chk("t1_ins0", 64'(out_instr), 64'hf800_0000);
    tick();
    chk("t1_pc4", out_pc, 64'h4);
    chk("t1_ins1", 64'(out_instr), 64'hf800_8001);
    tick();
    chk("t1_pc8", out_pc, 64'h8);
    chk("t1_ins2", 64'(out_instr), 64'hf801_0002);

    // Backpressure fills the queue, then drains without gaps
    do_reset();
    out_ready = 1'b0;
    repeat (5) tick();
    chk("t2_hold_pc", out_pc, 64'h0);
    chk("t2_hold_addr", 64'(imem_addr), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stream_valid", 64'(out_valid), 64'd1);
      chk("t2_stream_pc", out_pc, 64'(4 * i));
      tick();
    end

    // Redirect with a full queue
    out_ready = 1'b0;
    tick(); tick();
    out_ready = 1'b1; br_taken = 1'b1; br_target = 64'h43;
    tick();
    br_taken = 1'b0;
    chk("t3_flush_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t3_pc", out_pc, 64'h40);
    chk("t3_ins", 64'(out_instr), 64'(rom(6'd16)));

    // Debug held high while fetch wants the port
    dbg_req = 1'b1; dbg_addr = 6'd5;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t4_gnt_pattern", 64'(dbg_gnt), 64'(pat[i]));
      tick();
      if (pat[i]) begin
        chk("t4_dbg_valid", 64'(dbg_valid), 64'd1);
        chk("t4_dbg_data", 64'(dbg_data), 64'(rom(6'd5)));
      end
    end
    dbg_req = 1'b0;

    // ROM address wrap
    br_taken = 1'b1; br_target = 64'hFC;
    tick();
    br_taken = 1'b0;
    chk("t5_addr63", 64'(imem_addr), 64'd63);
    tick();
    chk("t5_addr0", 64'(imem_addr), 64'd0);
    chk("t5_pcFC", out_pc, 64'hFC);
    tick();
    chk("t5_pc100", out_pc, 64'h100);
    chk("t5_ins100", 64'(out_instr), 64'(rom(6'd0)));

    // Reset with a full queue and a debug read in flight
    out_ready = 1'b0;
    repeat (3) tick();
    dbg_req = 1'b1; dbg_addr = 6'd9;
    tick();
    dbg_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_dbg_valid", 64'(dbg_valid), 64'd0);
    chk("t6_addr", 64'(imem_addr), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom_range(3) != 0);
      br_taken  = ($urandom_range(15) == 0);
      br_target = {$urandom, $urandom};
      reset     = ($urandom_range(99) == 0);
      if (!dbg_req || m_last_gnt) begin
        dbg_req  = ($urandom_range(2) == 0);
        dbg_addr = 6'($urandom_range(63));
      end
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
